// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared widths, pointer types and reset contents for the preg free list
package free_list_pkg;

    localparam int NUM_PREGS     = 128;
    localparam int NUM_ARCH      = 32;
    localparam int ROB_DEPTH     = 32;
    localparam int CKPT_DEPTH    = ROB_DEPTH;
    localparam int PREG_W        = $clog2(NUM_PREGS);
    localparam int ROB_W         = $clog2(ROB_DEPTH);
    localparam int NUM_INIT_FREE = NUM_PREGS - NUM_ARCH;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [ROB_W-1:0]  rob_tag_t;
    // Extra MSB is the wrap bit so full and empty are distinguishable.
    typedef logic [PREG_W:0]   fl_ptr_t;

    // Only the read pointer is snapshotted; frees must survive a recovery.
    typedef struct packed {
        fl_ptr_t head;
    } fl_ptrs_snapshot_t;

    localparam fl_ptr_t INIT_TAIL  = fl_ptr_t'(NUM_INIT_FREE);
    localparam fl_ptr_t FULL_COUNT = fl_ptr_t'(NUM_PREGS);

    // Post-reset contents: architectural pregs are mapped, the rest are free in order.
    function automatic preg_t init_entry(input int idx);
        return (idx < NUM_INIT_FREE) ? preg_t'(NUM_ARCH + idx) : '0;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - control, allocate and free signals between pipeline and free list
// master: rename/ROB/recovery side driving requests; slave: the free list.
interface free_list_if;

    logic                      flush_i;
    logic                      recover_i;
    free_list_pkg::rob_tag_t   recover_tag_i;
    logic                      checkpoint_take_i;
    free_list_pkg::rob_tag_t   checkpoint_tag_i;
    logic                      alloc_req_i;
    logic                      alloc_valid_o;
    free_list_pkg::preg_t      alloc_preg_o;
    logic                      free_req_i;
    free_list_pkg::preg_t      free_preg_i;
    free_list_pkg::fl_ptr_t    free_count_o;

    modport master (
        output flush_i, recover_i, recover_tag_i, checkpoint_take_i, checkpoint_tag_i,
        output alloc_req_i, free_req_i, free_preg_i,
        input  alloc_valid_o, alloc_preg_o, free_count_o
    );

    modport slave (
        input  flush_i, recover_i, recover_tag_i, checkpoint_take_i, checkpoint_tag_i,
        input  alloc_req_i, free_req_i, free_preg_i,
        output alloc_valid_o, alloc_preg_o, free_count_o
    );

endinterface

// File: rtl/free_list_ckpt_ram.sv
// rtl/free_list_ckpt_ram.sv - per-ROB-tag read pointer snapshots, one write and one async read port
// Ports: clk, rst (async high), clr (sync clear), wr_en/wr_tag/wr_data, rd_tag/rd_data.
module free_list_ckpt_ram import free_list_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  rob_tag_t          wr_tag,
    input  fl_ptrs_snapshot_t wr_data,
    input  rob_tag_t          rd_tag,
    output fl_ptrs_snapshot_t rd_data
);

    fl_ptrs_snapshot_t slots_q [CKPT_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CKPT_DEPTH; i++) slots_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < CKPT_DEPTH; i++) slots_q[i] <= '0;
        end else if (wr_en) begin
            slots_q[wr_tag] <= wr_data;
        end
    end

    assign rd_data = slots_q[rd_tag];

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free physical registers with checkpointed read pointer
// Ports: clk, rst (async high), bus (free_list_if.slave): flush, recover/tag,
// checkpoint take/tag, show-ahead alloc handshake, free request, free count.
module free_list import free_list_pkg::*; (
    input logic       clk,
    input logic       rst,
    free_list_if.slave bus
);

    preg_t             mem_q [NUM_PREGS];
    fl_ptr_t           head_q;
    fl_ptr_t           tail_q;
    fl_ptr_t           count;
    fl_ptr_t           head_next;
    logic              alloc_valid;
    logic              alloc_fire;
    logic              free_fire;
    logic              ckpt_wr;
    fl_ptrs_snapshot_t ckpt_wr_data;
    fl_ptrs_snapshot_t ckpt_rd_data;

    assign count = tail_q - head_q;

    // Flush/recover cycles never hand out a preg; a same-cycle free is not bypassed.
    assign alloc_valid = (count != '0) && !bus.flush_i && !bus.recover_i;
    assign alloc_fire  = bus.alloc_req_i && alloc_valid;
    // p0 is never a real free; a free into a full list is dropped.
    assign free_fire   = bus.free_req_i && (bus.free_preg_i != '0) && (count != FULL_COUNT);
    assign head_next   = alloc_fire ? head_q + fl_ptr_t'(1) : head_q;

    assign bus.alloc_valid_o = alloc_valid;
    assign bus.alloc_preg_o  = mem_q[head_q[PREG_W-1:0]];
    assign bus.free_count_o  = count;

    // Snapshot includes the checkpointing instruction's own allocation.
    assign ckpt_wr           = bus.checkpoint_take_i && !bus.flush_i && !bus.recover_i;
    assign ckpt_wr_data.head = head_next;

    free_list_ckpt_ram u_ckpt (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.flush_i),
        .wr_en   (ckpt_wr),
        .wr_tag  (bus.checkpoint_tag_i),
        .wr_data (ckpt_wr_data),
        .rd_tag  (bus.recover_tag_i),
        .rd_data (ckpt_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= INIT_TAIL;
            for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= init_entry(i);
        end else if (bus.flush_i) begin
            head_q <= '0;
            tail_q <= INIT_TAIL;
            for (int i = 0; i < NUM_PREGS; i++) mem_q[i] <= init_entry(i);
        end else begin
            // Recovery only rewinds head; the ROB keeps retiring, so frees still land.
            head_q <= bus.recover_i ? ckpt_rd_data.head : head_next;
            if (free_fire) begin
                mem_q[tail_q[PREG_W-1:0]] <= bus.free_preg_i;
                tail_q                    <= tail_q + fl_ptr_t'(1);
            end
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst) count <= FULL_COUNT);
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(bus.free_req_i && (bus.free_preg_i != '0) && (count == FULL_COUNT) && !bus.flush_i));

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register numbers.
- Sits between ROB commit (free_req/free_preg) and rename (allocation of new destination pregs).
- Supports per-ROB-tag checkpoints of the read pointer, so branch recovery returns speculatively allocated pregs in one cycle.
- Flush reinitialises the list to the post-reset state.

Parameters:
- NUM_PREGS, `NUM_PREGS (128), total physical registers, power of two.
- NUM_ARCH, 32, architectural registers; pregs 0..NUM_ARCH-1 are initially mapped and never initially free.
- CKPT_DEPTH, ooop_types::ROB_DEPTH, number of checkpoint slots, indexed by ROB tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  full pipeline flush; reinitialise list.
- recover_i  in  1  branch mispredict recovery.
- recover_tag_i  in  ROB_W  checkpoint slot to restore.
- checkpoint_take_i  in  1  snapshot read pointer this cycle.
- checkpoint_tag_i  in  ROB_W  slot to write the snapshot into.
- alloc_req_i  in  1  rename consumes alloc_preg_o this cycle.
- alloc_valid_o  out  1  a free preg is available.
- alloc_preg_o  out  PREG_W  preg at head (show-ahead).
- free_req_i  in  1  ROB commit returns a preg.
- free_preg_i  in  PREG_W  preg being returned.
- free_count_o  out  PREG_W+1  number of free pregs.

Behaviour:
- Storage: mem[NUM_PREGS] of PREG_W bits. Pointers head and tail are PREG_W+1 bits (MSB is the wrap bit), with natural wrap.
- count = tail - head, computed combinationally; free_count_o = count.
- Reset (async; effective immediately on rst assert):
  - mem[i] = NUM_ARCH+i for i < NUM_PREGS-NUM_ARCH, others 0.
  - head = 0; tail = NUM_PREGS-NUM_ARCH; checkpoint slots = 0.
  - Resulting outputs: free_count_o = 96, alloc_valid_o = 1, alloc_preg_o = 32.
- Outputs are combinational from state: alloc_preg_o = mem[head[PREG_W-1:0]]; alloc_valid_o = (count != 0) && !flush_i && !recover_i.
- alloc_fire = alloc_req_i && alloc_valid_o, giving zero-latency pop: head advances at the next edge. alloc_req_i while empty is ignored (no pop, pointer unchanged).
- free_fire = free_req_i && (free_preg_i != 0): write mem[tail], tail+1 at the edge.
  - A free of p0 is silently dropped.
  - A free with count == NUM_PREGS is an overflow: dropped and flagged by an assertion.
- A free is never bypassed to alloc in the same cycle. If empty with a simultaneous free, alloc_valid_o = 0 that cycle and 1 next cycle.
- Priority per edge: rst > flush_i > recover_i > normal.
- flush_i: same state as reset except checkpoint slots are cleared too. All frees and allocs that cycle are dropped.
- recover_i:
  - head <= ckpt[recover_tag_i]; alloc is suppressed.
  - A free_fire in the same cycle is still honoured (tail+1, mem written), since the ROB retires during recover.
  - Checkpoint_take that cycle is ignored.
- Checkpoint:
  - On checkpoint_take_i (normal cycle), ckpt[checkpoint_tag_i] <= head_next.
  - head_next = head+1 if alloc_fire else head; the snapshot therefore includes the checkpointing instruction's own allocation.
  - Frees never touch head, so restored lists keep every preg freed since the snapshot.
- count arithmetic: alloc and free in the same cycle leave count unchanged; pointers move independently.
- Invariant for assertions: count <= NUM_PREGS at all times.

Decomposition:
- ooop_types owns PREG_W, ROB_W, ROB_DEPTH, and a new fl_ptr_t (PREG_W+1 bits).
- checkpoint_types gains fl_ptrs_snapshot_t (head only).
- No sub-module required. The checkpoint array may optionally be factored as fl_ckpt_ram: CKPT_DEPTH x fl_ptr_t, 1 write + 1 async read port.

Test Plan:
- Reset then 96 back-to-back alloc_req_i: returns pregs 32..127 in order. Then alloc_valid_o = 0 and free_count_o = 0; a 97th req leaves head unchanged.
- From empty, free p5 with alloc_req_i high the same cycle: no alloc that cycle. Next cycle alloc_valid_o = 1, alloc_preg_o = 5, free_count_o = 1.
- free_preg_i = 0 with free_req_i = 1: free_count_o unchanged, mem/tail unchanged.
- Checkpoint tag 3 together with an alloc of 32, then alloc 33, 34, then free p7, then recover tag 3:
  - free_count_o = 96 - 1 + 1 = 96.
  - alloc_preg_o = 33, and 34 follows.
  - p7 is at the tail after the initial 96 entries.
- Wrap-around: run 300 alloc/free pairs with random pregs. A scoreboard queue must match alloc_preg_o order, and count stays constant.
- Flush after 10 allocs and 4 frees: free_count_o = 96, alloc_preg_o = 32. rst asserted mid-sequence gives the same values with no clock edge required.
